// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline stages and the pipeline controller.
// The master side is the pipeline/divider (drives requests, observes control),
// the slave side is the controller itself.
interface pipeline_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        div_req_i;
  logic        div_done_i;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_timeout_o;
  logic [15:0] stall_cnt_o;

  modport master (
    output stallreq_id,
    output stallreq_ex,
    output div_req_i,
    output div_done_i,
    output excepttype_i,
    output cp0_epc_i,
    input  stall_o,
    input  flush_o,
    input  new_pc_o,
    input  div_start_o,
    input  div_annul_o,
    input  div_timeout_o,
    input  stall_cnt_o
  );

  modport slave (
    input  stallreq_id,
    input  stallreq_ex,
    input  div_req_i,
    input  div_done_i,
    input  excepttype_i,
    input  cp0_epc_i,
    output stall_o,
    output flush_o,
    output new_pc_o,
    output div_start_o,
    output div_annul_o,
    output div_timeout_o,
    output stall_cnt_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: resolves hazard stalls, sequences the multi-cycle
// divider (start, wait, timeout abort) and redirects the PC on exceptions.
// All control outputs are combinational so they take effect in the same cycle.
module pipeline_ctrl (
  input  logic          clk,
  input  logic          rst,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_t;

  // Stall patterns: EX-level stall holds PC..EX, ID-level stall holds PC..ID.
  localparam logic [5:0]  STALL_NONE  = 6'b000000;
  localparam logic [5:0]  STALL_ID    = 6'b000111;
  localparam logic [5:0]  STALL_EX    = 6'b001111;
  localparam logic [5:0]  DIV_LIMIT   = 6'd40;
  localparam logic [31:0] VEC_INT     = 32'h0000_0020;
  localparam logic [31:0] VEC_GENERAL = 32'h0000_0040;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  state_t      state_q, state_d;
  logic [5:0]  waitCnt_q, waitCnt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stallCnt_q, stallCnt_d;

  logic        excActive;
  logic [31:0] excTarget;
  logic [5:0]  stallVec;
  logic        flush;
  logic [31:0] newPc;
  logic        divStart;
  logic        divAnnul;

  assign excActive = (bus.excepttype_i != 32'h0);

  // Exception redirect target: interrupts vector low, eret returns to EPC,
  // every other exception type goes to the general vector.
  always_comb begin
    excTarget = VEC_GENERAL;
    case (bus.excepttype_i)
      EXC_INT:  excTarget = VEC_INT;
      EXC_ERET: excTarget = bus.cp0_epc_i;
      default:  excTarget = VEC_GENERAL;
    endcase
  end

  // Next-state and output decode, priority exception > div done > timeout >
  // div start > EX stall > ID stall; everything is forced quiet during reset.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    timeout_d = timeout_q;
    stallVec  = STALL_NONE;
    flush     = 1'b0;
    newPc     = 32'h0;
    divStart  = 1'b0;
    divAnnul  = 1'b0;
    if (!rst) begin
      if (excActive) begin
        flush    = 1'b1;
        newPc    = excTarget;
        divAnnul = (state_q == DIV_WAIT);
        state_d  = RUN;
      end else if (state_q == DIV_WAIT) begin
        if (bus.div_done_i) begin
          state_d = RUN;
        end else if (waitCnt_q == DIV_LIMIT) begin
          divAnnul  = 1'b1;
          timeout_d = 1'b1;
          state_d   = RUN;
        end else begin
          stallVec  = STALL_EX;
          waitCnt_d = waitCnt_q + 6'd1;
        end
      end else begin
        if (bus.div_req_i) begin
          divStart  = 1'b1;
          stallVec  = STALL_EX;
          waitCnt_d = 6'd0;
          state_d   = DIV_WAIT;
        end else if (bus.stallreq_ex) begin
          stallVec = STALL_EX;
        end else if (bus.stallreq_id) begin
          stallVec = STALL_ID;
        end
      end
    end
  end

  // Stalled-cycle performance counter, saturating at all ones.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if ((stallVec != STALL_NONE) && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      waitCnt_q  <= 6'd0;
      timeout_q  <= 1'b0;
      stallCnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      timeout_q  <= timeout_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign bus.stall_o       = stallVec;
  assign bus.flush_o       = flush;
  assign bus.new_pc_o      = newPc;
  assign bus.div_start_o   = divStart;
  assign bus.div_annul_o   = divAnnul;
  assign bus.div_timeout_o = timeout_q;
  assign bus.stall_cnt_o   = stallCnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural model.
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: whether a division is outstanding, how many wait
  // cycles it has spent, the sticky timeout flag and the stalled-cycle total.
  bit mValid;
  bit mInDiv;
  int mWaited;
  bit mTimeout;
  int mStallCnt;

  initial begin
    mValid    = 0;
    mInDiv    = 0;
    mWaited   = 0;
    mTimeout  = 0;
    mStallCnt = 0;
  end

  function automatic logic [31:0] vectorFor(logic [31:0] exc, logic [31:0] epc);
    if (exc == 32'h1) return 32'h20;
    if (exc == 32'he) return epc;
    return 32'h40;
  endfunction

  // Expected same-cycle outputs from the current model state and inputs.
  function automatic void expectComb(output logic [5:0] st, output logic fl,
                                     output logic [31:0] pc, output logic start,
                                     output logic annul);
    st = 0; fl = 0; pc = 0; start = 0; annul = 0;
    if (rst) return;
    if (bus.excepttype_i != 0) begin
      fl    = 1;
      pc    = vectorFor(bus.excepttype_i, bus.cp0_epc_i);
      annul = mInDiv;
    end else if (mInDiv) begin
      if (bus.div_done_i) st = 0;
      else if (mWaited == 40) annul = 1;
      else st = 6'b001111;
    end else if (bus.div_req_i) begin
      start = 1;
      st    = 6'b001111;
    end else if (bus.stallreq_ex) st = 6'b001111;
    else if (bus.stallreq_id) st = 6'b000111;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs of the ending cycle.
  always @(posedge clk) begin
    logic [5:0] st; logic fl; logic [31:0] pc; logic s, a;
    expectComb(st, fl, pc, s, a);
    if (rst) begin
      mValid = 1; mInDiv = 0; mWaited = 0; mTimeout = 0; mStallCnt = 0;
    end else if (mValid) begin
      if (st != 0 && mStallCnt < 65535) mStallCnt++;
      if (bus.excepttype_i != 0) mInDiv = 0;
      else if (mInDiv) begin
        if (bus.div_done_i) mInDiv = 0;
        else if (mWaited == 40) begin mInDiv = 0; mTimeout = 1; end
        else mWaited++;
      end else if (bus.div_req_i) begin
        mInDiv = 1; mWaited = 0;
      end
    end
  end

  // Compare every DUT output with the model mid-cycle.
  always @(negedge clk) begin
    logic [5:0] st; logic fl; logic [31:0] pc; logic s, a;
    if (mValid) begin
      expectComb(st, fl, pc, s, a);
      checkOutput("stall_o", {26'h0, bus.stall_o}, {26'h0, st});
      checkOutput("flush_o", {31'h0, bus.flush_o}, {31'h0, fl});
      checkOutput("new_pc_o", bus.new_pc_o, pc);
      checkOutput("div_start_o", {31'h0, bus.div_start_o}, {31'h0, s});
      checkOutput("div_annul_o", {31'h0, bus.div_annul_o}, {31'h0, a});
      checkOutput("div_timeout_o", {31'h0, bus.div_timeout_o}, {31'h0, mTimeout});
      checkOutput("stall_cnt_o", {16'h0, bus.stall_cnt_o}, mStallCnt[31:0]);
    end
  end

  // Drive one cycle's inputs shortly after the rising edge and return mid-cycle.
  task automatic applyStimulus(input logic r, input logic id, input logic ex,
                               input logic req, input logic done,
                               input logic [31:0] exc, input logic [31:0] epc);
    @(posedge clk);
    #1;
    rst              = r;
    bus.stallreq_id  = id;
    bus.stallreq_ex  = ex;
    bus.div_req_i    = req;
    bus.div_done_i   = done;
    bus.excepttype_i = exc;
    bus.cp0_epc_i    = epc;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] exc;
    checks = 0;
    errors = 0;
    rst = 1;
    bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.div_req_i = 0;
    bus.div_done_i = 0; bus.excepttype_i = 0; bus.cp0_epc_i = 0;

    // Reset masks every same-cycle output even with active requests.
    applyStimulus(1, 1, 1, 1, 1, 32'h1, 32'h1234);
    checkOutput("rst_stall", {26'h0, bus.stall_o}, 32'h0);
    checkOutput("rst_flush", {31'h0, bus.flush_o}, 32'h0);
    checkOutput("rst_newpc", bus.new_pc_o, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Hazard stalls and the counter.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("id_stall", {26'h0, bus.stall_o}, 32'h07);
    checkOutput("cnt_start", {16'h0, bus.stall_cnt_o}, 32'h0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("ex_stall", {26'h0, bus.stall_o}, 32'h0f);
    idle();
    checkOutput("cnt_two", {16'h0, bus.stall_cnt_o}, 32'h2);

    // Division finishing on the 33rd wait cycle.
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("div_start", {31'h0, bus.div_start_o}, 32'h1);
    for (int i = 0; i < 32; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("div_wait_stall", {26'h0, bus.stall_o}, 32'h0f);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("div_done_stall", {26'h0, bus.stall_o}, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("back_to_run", {26'h0, bus.stall_o}, 32'h07);

    // Division timeout on the 41st wait cycle, flag stays set.
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("tmo_cycle40_annul", {31'h0, bus.div_annul_o}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("tmo_annul", {31'h0, bus.div_annul_o}, 32'h1);
    checkOutput("tmo_release", {26'h0, bus.stall_o}, 32'h0);
    idle();
    checkOutput("tmo_sticky", {31'h0, bus.div_timeout_o}, 32'h1);
    for (int i = 0; i < 3; i++) idle();
    checkOutput("tmo_still", {31'h0, bus.div_timeout_o}, 32'h1);

    // Exceptions.
    applyStimulus(0, 1, 1, 1, 0, 32'h1, 32'h0);
    checkOutput("int_flush", {31'h0, bus.flush_o}, 32'h1);
    checkOutput("int_pc", bus.new_pc_o, 32'h20);
    checkOutput("int_nostall", {26'h0, bus.stall_o}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'he, 32'hBFC00100);
    checkOutput("eret_pc", bus.new_pc_o, 32'hBFC00100);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle();
    applyStimulus(0, 0, 0, 0, 0, 32'h8, 32'h0);
    checkOutput("exc_div_flush", {31'h0, bus.flush_o}, 32'h1);
    checkOutput("exc_div_annul", {31'h0, bus.div_annul_o}, 32'h1);
    checkOutput("exc_div_stall", {26'h0, bus.stall_o}, 32'h0);
    checkOutput("exc_div_pc", bus.new_pc_o, 32'h40);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("exc_div_run", {26'h0, bus.stall_o}, 32'h07);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      exc = 0;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 7))
          0: exc = 32'h1;
          1: exc = 32'h8;
          2: exc = 32'ha;
          3: exc = 32'hc;
          4: exc = 32'hd;
          5: exc = 32'he;
          default: exc = $urandom | 32'h1;
        endcase
      end
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 24) == 0, exc, $urandom);
    end

    // Reset in the middle of a division.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_div_stall", {26'h0, bus.stall_o}, 32'h0);
    idle();
    checkOutput("post_rst_stall", {26'h0, bus.stall_o}, 32'h0);
    checkOutput("post_rst_cnt", {16'h0, bus.stall_cnt_o}, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("post_rst_run", {26'h0, bus.stall_o}, 32'h07);

    // Counter saturation.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("cnt_fffe", {16'h0, bus.stall_cnt_o}, 32'hFFFE);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    idle();
    checkOutput("cnt_sat", {16'h0, bus.stall_cnt_o}, 32'hFFFF);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port stallreq_id  input  1  ID stage requests a stall (load-use hazard).
REQ-004 SHALL have port stallreq_ex  input  1  EX stage requests a single-cycle stall (two-cycle multiply-accumulate).
REQ-005 SHALL have port div_req_i  input  1  EX holds a DIV/DIVU instruction that needs the multi-cycle divider.
REQ-006 SHALL have port div_done_i  input  1  divider result valid this cycle.
REQ-007 SHALL have port excepttype_i  input  32  exception type from MEM stage; zero means no exception.
REQ-008 SHALL have port cp0_epc_i  input  32  current CP0 EPC value.
REQ-009 SHALL have port stall_o  output  6  stage stall vector, bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB; 1 means hold.
REQ-010 SHALL have port flush_o  output  1  flush all pipeline registers.
REQ-011 SHALL have port new_pc_o  output  32  redirect target, valid while flush_o=1.
REQ-012 SHALL have port div_start_o  output  1  one-cycle start pulse to the divider.
REQ-013 SHALL have port div_annul_o  output  1  one-cycle abort pulse to the divider.
REQ-014 SHALL have port div_timeout_o  output  1  sticky error flag: divider did not finish in time.
REQ-015 SHALL have port stall_cnt_o  output  16  performance counter of stalled cycles.

Function
REQ-016 SHALL implement FSM states RUN and DIV_WAIT; stall_o, flush_o, new_pc_o, div_start_o and div_annul_o SHALL be combinational from state and inputs (same-cycle effect).
REQ-017 SHALL apply per-cycle priority: exception > div_done_i > timeout > div start > stallreq_ex > stallreq_id.
REQ-018 On excepttype_i != 0 (either state): flush_o=1, stall_o=6'b000000, next state RUN.
REQ-019 SHALL drive new_pc_o = 0x00000020 for type 0x1 (interrupt); 0x00000040 for 0x8, 0xa, 0xd, 0xc; cp0_epc_i for 0xe (eret); else 0x00000040. When flush_o=0, new_pc_o SHALL be 0.
REQ-020 An exception in DIV_WAIT SHALL also assert div_annul_o for that cycle.
REQ-021 In RUN with div_req_i=1 and no exception: div_start_o=1, stall_o=6'b001111, next state DIV_WAIT, wait counter cleared.
REQ-022 In DIV_WAIT: stall_o=6'b001111 each cycle; the 6-bit wait counter SHALL increment each cycle div_done_i=0.
REQ-023 In DIV_WAIT with div_done_i=1: stall_o=0 (EX consumes result), next state RUN.
REQ-024 When wait counter equals 40 and div_done_i=0: div_annul_o=1, div_timeout_o set (sticky), stall_o=0, next state RUN.
REQ-025 In RUN, no exception, no div start: stallreq_ex=1 gives stall_o=6'b001111; otherwise stallreq_id=1 gives 6'b000111; otherwise 6'b000000.
REQ-026 div_req_i SHALL be ignored in DIV_WAIT; a new start requires a return to RUN first.
REQ-027 stall_cnt_o SHALL increment by 1 on every cycle with stall_o != 0, saturating at 0xFFFF.

Reset
REQ-028 While rst=1, all combinational outputs SHALL be 0 (stall_o=6'b000000, flush_o=0, new_pc_o=0, div_start_o=0, div_annul_o=0), regardless of other inputs.
REQ-029 On the clock edge with rst=1: state=RUN, wait counter=0, div_timeout_o=0, stall_cnt_o=0.
REQ-030 Reset asserted in DIV_WAIT SHALL abandon the division; no div_annul_o pulse is required.

Verification
REQ-031 Hazard stalls: stallreq_id=1 for 1 cycle -> stall_o=000111 that cycle; stallreq_id=1 and stallreq_ex=1 together -> 001111; stall_cnt_o increments by 1 per stalled cycle.
REQ-032 Division: div_req_i=1 in RUN -> div_start_o pulse and stall_o=001111; div_done_i after 33 cycles -> stall_o=0 in the done cycle, back to RUN.
REQ-033 Division timeout: div_done_i held 0 -> div_annul_o pulse and stall release on the 41st DIV_WAIT cycle; div_timeout_o stays 1 until rst.
REQ-034 Exceptions: excepttype_i=0x1 -> flush_o=1, new_pc_o=0x20; excepttype_i=0xe with cp0_epc_i=0xBFC00100 -> new_pc_o=0xBFC00100; excepttype_i=0x8 during DIV_WAIT -> flush_o=1, div_annul_o=1, stall_o=0, state RUN.
REQ-035 Boundaries: stall_cnt_o preloaded at 0xFFFE plus 3 stalled cycles -> 0xFFFF; rst=1 mid-DIV_WAIT -> next cycle stall_o=0, counters 0.
